// File: rtl/flag_pkg.sv
// Shared types and helpers for the flag stripe generator.
package flag_pkg;

  // RRGGBB, two bits per channel
  typedef logic [5:0] color_t;

  // Each stripe is split into this many equal-height bands for the gradient
  localparam int BANDS = 5;

  // Ordered-dither mask for a gradient band: 1 selects the next stripe's colour.
  // Band 0 is all current colour, band 4 all next colour, bands 1..3 step
  // through 1/4, 1/2 and 3/4 coverage of a 2x2 cell.
  function automatic logic dither_sel(input logic [2:0] band,
                                      input logic       x0,
                                      input logic       y0);
    logic sel;
    case (band)
      3'd0:    sel = 1'b0;
      3'd1:    sel = x0 & y0;
      3'd2:    sel = x0 ^ y0;
      3'd3:    sel = ~(x0 & y0);
      default: sel = 1'b1;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/flag_palette.sv
// Stripe colour palette: one flop entry per stripe, one write port and two
// combinational read ports. Writes to indices >= NUM_STRIPES are dropped, and
// reads of such indices return black.
module flag_palette
  import flag_pkg::*;
#(
  parameter int NUM_STRIPES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [3:0] waddr,
  input  color_t     wdata,
  input  logic [3:0] raddr_a,
  output color_t     rdata_a,
  input  logic [3:0] raddr_b,
  output color_t     rdata_b
);

  color_t mem [NUM_STRIPES];

  // Entry storage; a write becomes visible on the following cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STRIPES; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_STRIPES; i++) begin
        if (we && (waddr == 4'(i))) mem[i] <= wdata;
      end
    end
  end

  // Read port A (current stripe)
  always_comb begin
    rdata_a = '0;
    for (int i = 0; i < NUM_STRIPES; i++) begin
      if (raddr_a == 4'(i)) rdata_a = mem[i];
    end
  end

  // Read port B (next stripe, gradient target)
  always_comb begin
    rdata_b = '0;
    for (int i = 0; i < NUM_STRIPES; i++) begin
      if (raddr_b == 4'(i)) rdata_b = mem[i];
    end
  end

endmodule

// File: rtl/flag_stripe_gen.sv
// Horizontal-stripe flag pattern generator for a VGA pixel pipeline.
// Stripe selection comes from a line tracker (stripe s, sub-row r) that steps
// once per visible line, so no divide of pix_y is needed. An optional dithered
// gradient blends one stripe into the next over five bands.
// Build option: define FLAG_SCROLL_EN to enable vertical scrolling, which
// advances the tracker's frame-start position by one line every SCROLL_DIV
// frame_tick pulses. Without it the frame always starts at (0,0) and
// frame_tick has no effect.
module flag_stripe_gen
  import flag_pkg::*;
#(
  parameter int NUM_STRIPES = 6,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int SCROLL_DIV  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       video_active,
  input  logic       frame_tick,
  input  logic       pal_we,
  input  logic [3:0] pal_addr,
  input  logic [5:0] pal_data,
  input  logic       grad_en,
  input  logic [3:0] grad_idx,
  output logic [5:0] color
);

  localparam int STRIPE_H = V_ACTIVE / NUM_STRIPES;
  localparam int BAND_H   = STRIPE_H / BANDS;
  localparam int RW       = (STRIPE_H > 1) ? $clog2(STRIPE_H) : 1;

  localparam logic [3:0]    S_LAST  = 4'(NUM_STRIPES - 1);
  localparam logic [RW-1:0] R_LAST  = RW'(STRIPE_H - 1);
  localparam logic [9:0]    X_END   = 10'(H_ACTIVE);
  localparam logic [9:0]    Y_LOAD  = 10'(V_TOTAL - 1);
  localparam logic [9:0]    Y_VLAST = 10'(V_ACTIVE - 1);
  localparam logic [RW-1:0] B1 = RW'(BAND_H);
  localparam logic [RW-1:0] B2 = RW'(2 * BAND_H);
  localparam logic [RW-1:0] B3 = RW'(3 * BAND_H);
  localparam logic [RW-1:0] B4 = RW'(4 * BAND_H);

  // Reject geometries the tracker and band decode cannot represent
  if (NUM_STRIPES < 2 || NUM_STRIPES > 16) begin : g_bad_stripes
    $error("flag_stripe_gen: NUM_STRIPES must be 2..16");
  end
  if ((V_ACTIVE % NUM_STRIPES) != 0 || (STRIPE_H % BANDS) != 0) begin : g_bad_geom
    $error("flag_stripe_gen: V_ACTIVE/NUM_STRIPES must be an integer multiple of 5");
  end
  if (SCROLL_DIV < 1 || SCROLL_DIV > 15) begin : g_bad_div
    $error("flag_stripe_gen: SCROLL_DIV must be 1..15");
  end

  // One-line step of a (stripe, sub-row) pair, shared by tracker and scroll
  function automatic logic [3:0] next_s(input logic [3:0] s_in, input logic [RW-1:0] r_in);
    if (r_in != R_LAST) return s_in;
    return (s_in == S_LAST) ? 4'd0 : s_in + 4'd1;
  endfunction

  function automatic logic [RW-1:0] next_r(input logic [RW-1:0] r_in);
    return (r_in == R_LAST) ? '0 : r_in + RW'(1);
  endfunction

  logic [3:0]    trk_s;
  logic [RW-1:0] trk_r;
  logic [3:0]    scroll_s;
  logic [RW-1:0] scroll_r;
  logic          line_end;

  assign line_end = (pix_x == X_END);

`ifdef FLAG_SCROLL_EN
  logic [3:0] frame_cnt;
  localparam logic [3:0] FC_LAST = 4'(SCROLL_DIV - 1);

  // Frame divider and scroll position; the tracker samples the old pair, so a
  // tick coinciding with the frame load takes effect on the following frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      scroll_s  <= '0;
      scroll_r  <= '0;
    end else if (frame_tick) begin
      if (frame_cnt == FC_LAST) begin
        frame_cnt <= '0;
        scroll_s  <= next_s(scroll_s, scroll_r);
        scroll_r  <= next_r(scroll_r);
      end else begin
        frame_cnt <= frame_cnt + 4'd1;
      end
    end
  end
`else
  logic frame_tick_unused;
  assign frame_tick_unused = frame_tick;
  assign scroll_s = '0;
  assign scroll_r = '0;
`endif

  // Line tracker: load at end of the last frame line, step on visible lines
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trk_s <= '0;
      trk_r <= '0;
    end else if (line_end) begin
      if (pix_y == Y_LOAD) begin
        trk_s <= scroll_s;
        trk_r <= scroll_r;
      end else if (pix_y < Y_VLAST) begin
        trk_s <= next_s(trk_s, trk_r);
        trk_r <= next_r(trk_r);
      end
    end
  end

  logic [3:0] s_nxt;
  color_t     col_a;
  color_t     col_b;

  assign s_nxt = (trk_s == S_LAST) ? 4'd0 : trk_s + 4'd1;

  flag_palette #(.NUM_STRIPES(NUM_STRIPES)) u_palette (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (pal_we),
    .waddr   (pal_addr),
    .wdata   (pal_data),
    .raddr_a (trk_s),
    .rdata_a (col_a),
    .raddr_b (s_nxt),
    .rdata_b (col_b)
  );

  logic [2:0] band;
  logic       grad_hit;
  color_t     pix_col;

  // Band of the current sub-row, by constant thresholds
  always_comb begin
    band = 3'd4;
    if (trk_r < B1)      band = 3'd0;
    else if (trk_r < B2) band = 3'd1;
    else if (trk_r < B3) band = 3'd2;
    else if (trk_r < B4) band = 3'd3;
  end

  // Pixel colour: base stripe colour, or dithered blend on the gradient stripe
  always_comb begin
    grad_hit = grad_en && (grad_idx == trk_s) && ({1'b0, grad_idx} < 5'(NUM_STRIPES));
    pix_col  = col_a;
    if (grad_hit && dither_sel(band, pix_x[0], pix_y[0])) pix_col = col_b;
  end

  // Output register, blanked outside the visible area
  always_ff @(posedge clk) begin
    if (!rst_n)            color <= '0;
    else if (video_active) color <= pix_col;
    else                   color <= '0;
  end

endmodule

// File: tb/tb_flag_stripe_gen.sv
module tb_flag_stripe_gen;

  localparam int NS = 6;
  localparam int VA = 480;
  localparam int VT = 525;
  localparam int HA = 640;
  localparam int SD = 2;
  localparam int SH = VA / NS;
  localparam int BH = SH / 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pix_x, pix_y;
  logic       video_active, frame_tick;
  logic       pal_we;
  logic [3:0] pal_addr;
  logic [5:0] pal_data;
  logic       grad_en;
  logic [3:0] grad_idx;
  logic [5:0] color;

  always #5 clk = ~clk;

  flag_stripe_gen #(
    .NUM_STRIPES(NS), .V_ACTIVE(VA), .V_TOTAL(VT), .H_ACTIVE(HA), .SCROLL_DIV(SD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .video_active(video_active), .frame_tick(frame_tick),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .grad_en(grad_en), .grad_idx(grad_idx), .color(color)
  );

  int checks = 0;
  int failures = 0;

  // reference state
  logic [5:0] pal_m [NS];
  int cur_off, pend_off, fcnt_m;

  // scoreboard
  logic [5:0] exp_q [$];
  string      name_q [$];

  typedef struct {
    int         mode;
    int         y;
    int         x;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl [$];

  // Reference colour computed directly from the row number
  function automatic logic [5:0] model(input logic [9:0] x, input logic [9:0] y);
    int l, s, r, b;
    logic sel;
    l = (cur_off + int'(y)) % VA;
    s = l / SH;
    r = l % SH;
    b = r / BH;
    sel = 1'b0;
    if (grad_en && int'(grad_idx) == s) begin
      case (b)
        0: sel = 1'b0;
        1: sel = x[0] & y[0];
        2: sel = x[0] ^ y[0];
        3: sel = !(x[0] & y[0]);
        default: sel = 1'b1;
      endcase
    end
    return sel ? pal_m[(s + 1) % NS] : pal_m[s];
  endfunction

  task automatic check_out();
    logic [5:0] e;
    string nm;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    checks++;
    if (color !== e) begin
      failures++;
      $display("FAIL %s: color=%02h expected=%02h", nm, color, e);
    end
  endtask

  task automatic step_exp(input logic [9:0] x, input logic [9:0] y, input logic va,
                          input logic [5:0] e, input string nm);
    pix_x = x;
    pix_y = y;
    video_active = va;
    exp_q.push_back(rst_n ? e : 6'd0);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic va, input string nm);
    logic [5:0] e;
    e = va ? model(x, y) : 6'd0;
    step_exp(x, y, va, e, nm);
  endtask

  task automatic apply_tick();
`ifdef FLAG_SCROLL_EN
    fcnt_m++;
    if (fcnt_m == SD) begin
      fcnt_m = 0;
      pend_off = (pend_off + 1) % VA;
    end
`endif
  endtask

  task automatic pal_write(input int a, input logic [5:0] d);
    pal_we = 1'b1;
    pal_addr = 4'(a);
    pal_data = d;
    step(10'd700, 10'd500, 1'b0, "pal_wr");
    pal_we = 1'b0;
    if (a < NS) pal_m[a] = d;
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    for (int i = 0; i < n; i++) begin
      step(10'd700, 10'd500, 1'b0, "tick");
      apply_tick();
    end
    frame_tick = 1'b0;
  endtask

  task automatic load_line(input logic tick);
    frame_tick = tick;
    step(10'(HA), 10'(VT - 1), 1'b0, "load");
    frame_tick = 1'b0;
    cur_off = pend_off;
    if (tick) apply_tick();
  endtask

  // Visible rows y0..y1-1: a few model pixels, table vectors, then line end
  task automatic rows(input int mode, input int y0, input int y1);
    for (int y = y0; y < y1; y++) begin
      for (int x = 0; x < 3; x++)
        step(10'(x), 10'(y), 1'b1, $sformatf("pix m%0d y%0d x%0d", mode, y, x));
      foreach (tbl[i])
        if (tbl[i].mode == mode && tbl[i].y == y)
          step_exp(10'(tbl[i].x), 10'(y), 1'b1, tbl[i].exp,
                   $sformatf("vec m%0d y%0d x%0d", mode, y, tbl[i].x));
      step(10'(HA), 10'(y), 1'b0, "line_end");
    end
    if (y1 == VA) step(10'(HA), 10'd500, 1'b0, "blank_end");
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) pal_m[i] = 6'd0;
    cur_off = 0;
    pend_off = 0;
    fcnt_m = 0;
  endtask

  initial begin
    // mode 0: no gradient; mode 1: gradient on stripe 2; modes 2/3: scrolled
    tbl.push_back('{0,   0, 0, 6'h3B});
    tbl.push_back('{0,  79, 1, 6'h3B});
    tbl.push_back('{0,  80, 0, 6'h3F});
    tbl.push_back('{0, 159, 1, 6'h3F});
    tbl.push_back('{0, 160, 1, 6'h2A});
    tbl.push_back('{0, 479, 0, 6'h3B});
    tbl.push_back('{1, 160, 1, 6'h2A});
    tbl.push_back('{1, 177, 0, 6'h2A});
    tbl.push_back('{1, 177, 1, 6'h3A});
    tbl.push_back('{1, 192, 0, 6'h2A});
    tbl.push_back('{1, 192, 1, 6'h3A});
    tbl.push_back('{1, 193, 0, 6'h3A});
    tbl.push_back('{1, 193, 1, 6'h2A});
    tbl.push_back('{1, 208, 0, 6'h3A});
    tbl.push_back('{1, 209, 1, 6'h2A});
    tbl.push_back('{1, 239, 0, 6'h3A});
    tbl.push_back('{1, 239, 1, 6'h3A});
    tbl.push_back('{1, 240, 0, 6'h3A});
    tbl.push_back('{2,   0, 0, 6'h3B});
    tbl.push_back('{2,  77, 1, 6'h3B});
    tbl.push_back('{2,  78, 0, 6'h3F});
    tbl.push_back('{3,   0, 0, 6'h15});
    tbl.push_back('{3,   1, 0, 6'h3B});
    tbl.push_back('{3,  80, 0, 6'h3B});
    tbl.push_back('{3,  81, 0, 6'h3F});

    model_reset();
    rst_n = 1'b0;
    pix_x = '0; pix_y = '0; video_active = 1'b0; frame_tick = 1'b0;
    pal_we = 1'b0; pal_addr = '0; pal_data = '0;
    grad_en = 1'b0; grad_idx = '0;

    // reset: output forced black even with video_active high
    step(10'd3, 10'd0, 1'b1, "reset");
    step(10'd4, 10'd0, 1'b1, "reset");
    rst_n = 1'b1;
    step(10'd4, 10'd0, 1'b1, "post_reset_black_pal");

    pal_write(0, 6'h3B);
    pal_write(1, 6'h3F);
    pal_write(2, 6'h2A);
    pal_write(3, 6'h3A);
    pal_write(4, 6'h3F);
    pal_write(5, 6'h3B);
    pal_write(7, 6'h01);

    // write-through timing: same-cycle read sees the old entry
    pal_we = 1'b1; pal_addr = 4'd0; pal_data = 6'h05;
    step(10'd2, 10'd0, 1'b1, "pal_same_cycle_old");
    pal_we = 1'b0;
    pal_m[0] = 6'h05;
    step(10'd2, 10'd0, 1'b1, "pal_next_cycle_new");
    step_exp(10'd5, 10'd10, 1'b0, 6'd0, "inactive_black");
    pal_write(0, 6'h3B);

    load_line(1'b0);
    rows(0, 0, VA);

    grad_en = 1'b1; grad_idx = 4'd2;
    load_line(1'b0);
    rows(1, 0, VA);

    grad_idx = 4'd7;
    load_line(1'b0);
    rows(0, 0, VA);

    grad_idx = 4'd5;
    pal_write(0, 6'h05);
    load_line(1'b0);
    rows(-1, 0, VA);
    pal_write(0, 6'h3B);
    grad_en = 1'b0;

`ifdef FLAG_SCROLL_EN
    ticks(4);
    load_line(1'b0);
    rows(2, 0, VA);
    pal_write(5, 6'h15);
    ticks(955);
    load_line(1'b1);
    rows(3, 0, VA);
    pal_write(5, 6'h3B);
    load_line(1'b0);
    rows(0, 0, VA);
`else
    ticks(5);
    load_line(1'b1);
    rows(0, 0, VA);
`endif

    // mid-line reset, then everything black until the palette is rewritten
    load_line(1'b0);
    rows(0, 0, 100);
    step(10'd0, 10'd100, 1'b1, "pre_reset_pix");
    rst_n = 1'b0;
    step_exp(10'd1, 10'd100, 1'b1, 6'd0, "reset_mid_line");
    rst_n = 1'b1;
    model_reset();
    rows(-1, 101, VA);
    load_line(1'b0);
    rows(-1, 0, VA);

    pal_write(0, 6'h3B);
    pal_write(1, 6'h3F);
    pal_write(2, 6'h2A);
    pal_write(3, 6'h3A);
    pal_write(4, 6'h3F);
    pal_write(5, 6'h3B);
    load_line(1'b0);
    rows(0, 0, VA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flag_stripe_gen.md
FLAG_STRIPE_GEN -- requirements
Module: flag_stripe_gen

Interface
REQ-001 Parameter NUM_STRIPES, default 6: number of horizontal stripes, 2..16.
REQ-002 Parameter V_ACTIVE, default 480: visible lines.
REQ-003 Parameter V_TOTAL, default 525: total lines per frame.
REQ-004 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-005 Parameter SCROLL_DIV, default 2: frames per one-line scroll step, 1..15.
REQ-006 clk  input  1  pixel clock; the block's only clock.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 pix_x  input  10  current pixel column from the VGA timing generator.
REQ-009 pix_y  input  10  current pixel row.
REQ-010 video_active  input  1  high inside the visible area.
REQ-011 frame_tick  input  1  one-cycle pulse, once per frame, during vertical blanking.
REQ-012 pal_we / pal_addr[3:0] / pal_data[5:0]  input  palette write strobe, index, RRGGBB colour.
REQ-013 grad_en / grad_idx[3:0]  input  enable a dithered gradient from stripe grad_idx into stripe grad_idx+1.
REQ-014 color  output  6  registered RRGGBB pixel colour.

Function
REQ-015 Elaboration SHALL fail unless V_ACTIVE mod NUM_STRIPES == 0 and STRIPE_H = V_ACTIVE/NUM_STRIPES is divisible by 5; BAND_H = STRIPE_H/5.
REQ-016 color SHALL have one-cycle latency: it reflects pix_x, pix_y, video_active and tracker state of the previous cycle.
REQ-017 color SHALL be 0 when video_active was low.
REQ-018 A line tracker (stripe index s, sub-row r) SHALL update only at line end (pix_x == H_ACTIVE).
REQ-019 Line end with pix_y == V_TOTAL-1: tracker loads the scroll pair (scroll_s, scroll_r).
REQ-020 Line end with pix_y < V_ACTIVE-1: r increments; r == STRIPE_H-1 wraps r to 0 and increments s, with s == NUM_STRIPES-1 wrapping to 0.
REQ-021 Line end on any other line: tracker holds.
REQ-022 No divider or multiplier on pix_y SHALL be used; stripe selection comes only from the tracker.
REQ-023 Base colour SHALL be palette[s].
REQ-024 When grad_en is set and s == grad_idx, band b = r/BAND_H (compare against constants) SHALL select the colour. A = palette[s], B = palette[(s+1) mod NUM_STRIPES].
  - b0: A
  - b1: B where pix_x[0]&pix_y[0], else A
  - b2: B where pix_x[0]^pix_y[0], else A
  - b3: B unless pix_x[0]&pix_y[0]
  - b4: B
REQ-025 grad_idx >= NUM_STRIPES SHALL disable the gradient.
REQ-026 A palette write SHALL take effect on the cycle after pal_we; a same-cycle read returns the old value.
REQ-027 pal_addr >= NUM_STRIPES SHALL be ignored.
REQ-028 Scroll: a frame counter SHALL count frame_tick pulses modulo SCROLL_DIV. On wrap, the scroll pair advances one line, wrapping exactly as in REQ-020.
REQ-029 frame_tick coinciding with a tracker load SHALL load the pre-increment scroll pair.

Reset
REQ-030 When rst_n is sampled low, all of the following SHALL clear to 0: color, palette entries, tracker, scroll pair, frame counter.
REQ-031 Reset mid-frame SHALL yield black stripes, unscrolled, from the next frame load.

Configuration
REQ-032 Macro FLAG_SCROLL_EN defined: scroll behaves per REQ-028/029.
REQ-033 FLAG_SCROLL_EN undefined:
  - the scroll pair is constant (0,0);
  - the frame counter and scroll logic are absent;
  - frame_tick is ignored.

Structure
REQ-034 The shared package flag_pkg SHALL hold the colour typedef (6-bit RRGGBB), the dither pattern function, and the BAND count constant 5.
REQ-035 Palette storage SHALL be the sub-module flag_palette (NUM_STRIPES x 6 flops, one write port, two async read ports).

Verification
REQ-036 Program palette {0x3B,0x3F,0x2A,0x3A,0x3F,0x3B}, grad_en=0, no frame_tick, then run one frame -> rows 0..79 give 0x3B and rows 80..159 give 0x3F, one cycle after pix_y.
REQ-037 grad_en=1, grad_idx=2 -> row 160 gives 0x2A; row 192 gives checkerboard 0x2A/0x3A by pix_x^pix_y; row 239 gives 0x3A.
REQ-038 FLAG_SCROLL_EN, SCROLL_DIV=2, 4 frame_ticks -> next frame row 0 shows stripe 0, r=2; row 78 shows stripe 1.
REQ-039 scroll_r=79, scroll_s=5, frame_tick wraps the counter -> pair becomes (0,0); a coincident load uses (5,79).
REQ-040 pal_we to index 7 with NUM_STRIPES=6 -> no change; video_active=0 -> color=0.
REQ-041 rst_n low for one cycle mid-line -> color=0 next cycle, and the full next frame is black.
